// File: rtl/fp24_inv_sqrt_arbiter.sv
// fp24_inv_sqrt_arbiter: round-robin share of one pipelined fp24 inverse-sqrt unit among N_REQ requesters
//   clk, rst            clock, synchronous active-high reset
//   enable              gates new grants; in-flight ops still complete
//   req_x/req_valid     per-requester operands (24 bits each) and request strobes
//   req_ready           one-hot grant
//   unit_x/unit_valid   operand issue to the shared unit
//   unit_result(_valid) unit output, LATENCY cycles after issue
//   resp_data/resp_valid result broadcast with one-hot owner strobe
//   in_flight           accepted operands not yet returned
//   err_mismatch        sticky tag/result misalignment flag
module fp24_inv_sqrt_arbiter #(
   parameter int N_REQ = 4,
   parameter int LATENCY = 18,
   localparam int ID_W = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [24*N_REQ-1:0]   req_x,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   output logic [23:0]           unit_x,
   output logic                  unit_valid,
   input  logic [23:0]           unit_result,
   input  logic                  unit_result_valid,
   output logic [23:0]           resp_data,
   output logic [N_REQ-1:0]      resp_valid,
   output logic [4:0]            in_flight,
   output logic                  err_mismatch
);
   localparam int DW = $clog2(LATENCY + 1);
   logic [ID_W-1:0] ptr, g, issue_id, tag_id;
   logic [ID_W:0] tag_pipe [LATENCY];
   logic [DW-1:0] drain;
   logic hs, tag_v;
   // descending scan so the last hit is the nearest index at or after ptr
   always_comb begin
      g = '0;
      for (int k = N_REQ - 1; k >= 0; k--)
         if (req_valid[(int'(ptr) + k) % N_REQ]) g = ID_W'((int'(ptr) + k) % N_REQ);
   end
   assign req_ready = (enable && !rst && |req_valid) ? (N_REQ'(1) << g) : '0;
   assign hs = |(req_valid & req_ready);
   assign tag_v = tag_pipe[LATENCY-1][ID_W];
   assign tag_id = tag_pipe[LATENCY-1][ID_W-1:0];
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
         unit_x <= '0;
         unit_valid <= 1'b0;
         issue_id <= '0;
         for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
         drain <= DW'(LATENCY);
         resp_data <= '0;
         resp_valid <= '0;
         in_flight <= '0;
         err_mismatch <= 1'b0;
      end else begin
         if (hs) begin
            ptr <= (g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1;
            unit_x <= req_x[24*g +: 24];
            issue_id <= g;
         end
         unit_valid <= hs;
         tag_pipe[0] <= {unit_valid, issue_id};
         for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
         // stale unit results right after reset are dropped until the counter expires
         drain <= (drain != '0) ? drain - 1'b1 : drain;
         resp_valid <= (tag_v && unit_result_valid) ? (N_REQ'(1) << tag_id) : '0;
         if (tag_v && unit_result_valid) resp_data <= unit_result;
         if (drain == '0 && tag_v != unit_result_valid) err_mismatch <= 1'b1;
         in_flight <= in_flight + {4'd0, hs} - {4'd0, tag_v};
      end
   end
endmodule

// File: tb/tb_fp24_inv_sqrt_arbiter.sv
// tb_fp24_inv_sqrt_arbiter: scoreboard bench for fp24_inv_sqrt_arbiter with a fixed-delay unit model
module tb_fp24_inv_sqrt_arbiter;
   localparam int N = 4;
   localparam int L = 18;
   localparam logic [23:0] MASK = 24'h7F0000;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b1;
   logic [24*N-1:0] req_x = '0;
   logic [N-1:0] req_valid = '0;
   logic [N-1:0] req_ready, resp_valid;
   logic [23:0] unit_x, unit_result, resp_data;
   logic unit_valid, unit_result_valid, err_mismatch;
   logic [4:0] in_flight;
   int tests = 0, fails = 0, cyc = 0, n_resp = 0;
   logic [L-1:0] mv = '0;
   logic [23:0] md [L];
   logic spur = 1'b0;
   typedef struct { int id; logic [23:0] d; int t; } exp_t;
   exp_t sb [$];
   exp_t e;

   fp24_inv_sqrt_arbiter #(.N_REQ(N), .LATENCY(L)) dut (
      .clk(clk), .rst(rst), .enable(enable), .req_x(req_x), .req_valid(req_valid),
      .req_ready(req_ready), .unit_x(unit_x), .unit_valid(unit_valid),
      .unit_result(unit_result), .unit_result_valid(unit_result_valid),
      .resp_data(resp_data), .resp_valid(resp_valid), .in_flight(in_flight),
      .err_mismatch(err_mismatch)
   );

   always #5 clk = ~clk;

   // unit model: fixed delay, result = operand ^ MASK (4.0 -> 0.5), valid pipe never reset
   always @(posedge clk) begin
      cyc <= cyc + 1;
      mv <= {mv[L-2:0], unit_valid};
      md[0] <= unit_x ^ MASK;
      for (int k = 1; k < L; k++) md[k] <= md[k-1];
   end
   assign unit_result_valid = mv[L-1] | spur;
   assign unit_result = md[L-1];

   always @(negedge clk) begin
      if (resp_valid !== '0) begin
         n_resp++;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL resp_unexpected: cyc=%0d resp_valid=%b data=%h, required no response", cyc, resp_valid, resp_data);
         end else begin
            e = sb.pop_front();
            if (resp_valid !== 4'(1 << e.id) || resp_data !== e.d || cyc != e.t) begin
               fails++;
               $display("FAIL resp_match: got valid=%b data=%h cyc=%0d, required valid=%b data=%h cyc=%0d",
                        resp_valid, resp_data, cyc, 4'(1 << e.id), e.d, e.t);
            end
         end
      end
      while (sb.size() > 0 && sb[0].t < cyc) begin
         tests++;
         fails++;
         $display("FAIL resp_missing: no response by cyc=%0d, required id=%0d at cyc=%0d", cyc, sb[0].id, sb[0].t);
         void'(sb.pop_front());
      end
      if (rst) sb.delete();
      else for (int i = 0; i < N; i++)
         if (req_valid[i] && req_ready[i]) sb.push_back('{i, req_x[24*i +: 24] ^ MASK, cyc + L + 2});
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((in_flight !== 5'd0 || sb.size() != 0) && n < 100) begin
         step();
         n++;
      end
      tests++;
      if (n >= 100) begin
         fails++;
         $display("FAIL idle_timeout: in_flight=%0d pending=%0d, required 0 and 0", in_flight, sb.size());
      end
      repeat (3) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '1;
      repeat (3) step();
      @(negedge clk);
      tests++;
      if (req_ready !== 4'b0000) begin
         fails++;
         $display("FAIL reset_ready: got %b, required 0000", req_ready);
      end
      tests++;
      if ({unit_valid, resp_valid, in_flight, err_mismatch} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got uv=%b rv=%b if=%0d err=%b, required all 0", unit_valid, resp_valid, in_flight, err_mismatch);
      end
      step();
      rst = 1'b0;
      req_valid = '0;
      @(negedge clk);
      tests++;
      if (in_flight !== 5'd0 || err_mismatch !== 1'b0) begin
         fails++;
         $display("FAIL post_reset: got if=%0d err=%b, required 0 0", in_flight, err_mismatch);
      end
      step();
   endtask

   task automatic test_single();
      int t;
      req_x[48 +: 24] = 24'h410000;
      req_valid = 4'b0100;
      @(negedge clk);
      t = cyc;
      tests++;
      if (req_ready !== 4'b0100) begin
         fails++;
         $display("FAIL single_grant: got %b, required 0100", req_ready);
      end
      step();
      req_valid = '0;
      @(negedge clk);
      tests++;
      if (unit_valid !== 1'b1 || unit_x !== 24'h410000 || in_flight !== 5'd1) begin
         fails++;
         $display("FAIL single_issue: got uv=%b x=%h if=%0d, required 1 410000 1", unit_valid, unit_x, in_flight);
      end
      while (cyc < t + 19) @(negedge clk);
      tests++;
      if (in_flight !== 5'd1 || resp_valid !== 4'b0000) begin
         fails++;
         $display("FAIL single_pre: got if=%0d rv=%b, required 1 0000", in_flight, resp_valid);
      end
      @(negedge clk);
      tests++;
      if (resp_valid !== 4'b0100 || resp_data !== 24'h3E0000 || in_flight !== 5'd0) begin
         fails++;
         $display("FAIL single_resp: got rv=%b d=%h if=%0d, required 0100 3e0000 0", resp_valid, resp_data, in_flight);
      end
      wait_idle();
   endtask

   task automatic test_all_four();
      do_reset();
      for (int i = 0; i < N; i++) req_x[24*i +: 24] = 24'(24'h400000 + i);
      req_valid = '1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         tests++;
         if (req_ready !== 4'(1 << (k % 4))) begin
            fails++;
            $display("FAIL rr_order k=%0d: got %b, required %b", k, req_ready, 4'(1 << (k % 4)));
         end
         if (k == 10 || k == 30) begin
            tests++;
            if (in_flight !== ((k == 10) ? 5'd10 : 5'd19)) begin
               fails++;
               $display("FAIL rr_in_flight k=%0d: got %0d, required %0d", k, in_flight, (k == 10) ? 10 : 19);
            end
         end
         step();
         for (int i = 0; i < N; i++) req_x[24*i +: 24] = 24'(cyc * 16 + i);
      end
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_fairness();
      logic [N-1:0] ex;
      req_valid = 4'b1001;
      @(negedge clk);
      ex = req_ready;
      tests++;
      if (ex !== 4'b0001 && ex !== 4'b1000) begin
         fails++;
         $display("FAIL fair_first: got %b, required 0001 or 1000", ex);
      end
      for (int k = 0; k < 8; k++) begin
         step();
         @(negedge clk);
         ex = (ex == 4'b0001) ? 4'b1000 : 4'b0001;
         tests++;
         if (req_ready !== ex) begin
            fails++;
            $display("FAIL fair_alt k=%0d: got %b, required %b", k, req_ready, ex);
         end
      end
      step();
      req_valid = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         tests++;
         if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL fair_solo k=%0d: got %b, required 0001", k, req_ready);
         end
         step();
      end
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_enable();
      logic [N-1:0] last = '0;
      req_valid = 4'b0110;
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         last = req_ready;
         step();
      end
      enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         tests++;
         if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL en_ready k=%0d: got %b, required 0000", k, req_ready);
         end
         if (k > 0) begin
            tests++;
            if (unit_valid !== 1'b0) begin
               fails++;
               $display("FAIL en_issue k=%0d: got %b, required 0", k, unit_valid);
            end
         end
         if (k == 0 || k == 4) begin
            tests++;
            if (in_flight !== ((k == 0) ? 5'd18 : 5'd15)) begin
               fails++;
               $display("FAIL en_in_flight k=%0d: got %0d, required %0d", k, in_flight, (k == 0) ? 18 : 15);
            end
         end
         step();
      end
      enable = 1'b1;
      @(negedge clk);
      tests++;
      if (req_ready !== ((last == 4'b0010) ? 4'b0100 : 4'b0010)) begin
         fails++;
         $display("FAIL en_resume: got %b after last %b, required the other of 0010/0100", req_ready, last);
      end
      step();
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_midreset();
      int n = 0;
      req_valid = '1;
      repeat (10) step();
      rst = 1'b1;
      req_valid = '0;
      @(negedge clk);
      tests++;
      if (req_ready !== 4'b0000) begin
         fails++;
         $display("FAIL mr_ready: got %b, required 0000", req_ready);
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (in_flight !== 5'd0) begin
         fails++;
         $display("FAIL mr_in_flight: got %0d, required 0", in_flight);
      end
      repeat (3) step();
      req_x[24 +: 24] = 24'h420000;
      req_valid = 4'b0010;
      @(negedge clk);
      tests++;
      if (req_ready !== 4'b0010) begin
         fails++;
         $display("FAIL mr_grant: got %b, required 0010", req_ready);
      end
      step();
      req_valid = '0;
      @(negedge clk);
      while (resp_valid === '0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (resp_valid !== 4'b0010 || resp_data !== 24'h3D0000) begin
         fails++;
         $display("FAIL mr_resp: got rv=%b d=%h, required 0010 3d0000", resp_valid, resp_data);
      end
      tests++;
      if (err_mismatch !== 1'b0) begin
         fails++;
         $display("FAIL mr_err: got %b, required 0", err_mismatch);
      end
      wait_idle();
   endtask

   task automatic test_spurious();
      do_reset();
      repeat (30) step();
      spur = 1'b1;
      @(negedge clk);
      tests++;
      if (err_mismatch !== 1'b0) begin
         fails++;
         $display("FAIL sp_early: got %b, required 0", err_mismatch);
      end
      step();
      spur = 1'b0;
      @(negedge clk);
      tests++;
      if (err_mismatch !== 1'b1 || resp_valid !== 4'b0000) begin
         fails++;
         $display("FAIL sp_set: got err=%b rv=%b, required 1 0000", err_mismatch, resp_valid);
      end
      repeat (5) step();
      @(negedge clk);
      tests++;
      if (err_mismatch !== 1'b1) begin
         fails++;
         $display("FAIL sp_sticky: got %b, required 1", err_mismatch);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_fairness();
      test_enable();
      test_midreset();
      test_spurious();
      tests++;
      if (sb.size() != 0 || n_resp < 50) begin
         fails++;
         $display("FAIL final: pending=%0d responses=%0d, required 0 pending and at least 50", sb.size(), n_resp);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
